// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port, reservation, clear.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
);

  logic [NUM_RD*ADDR_W-1:0] RdAddr;
  logic [NUM_RD*DATA_W-1:0] RdData;
  logic [NUM_RD-1:0]        RdBusy;
  logic                     WrEn;
  logic [ADDR_W-1:0]        WrAddr;
  logic [DATA_W-1:0]        WrData;
  logic                     RsvEn;
  logic [ADDR_W-1:0]        RsvAddr;
  logic                     ClrReq;
  logic                     Ready;

  modport master (
    output RdAddr, WrEn, WrAddr, WrData, RsvEn, RsvAddr, ClrReq,
    input  RdData, RdBusy, Ready
  );

  modport slave (
    input  RdAddr, WrEn, WrAddr, WrData, RsvEn, RsvAddr, ClrReq,
    output RdData, RdBusy, Ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per entry with set, clear, clear-all and per-port lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     set_en_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic                     clr_en_i,
  input  logic [ADDR_W-1:0]        clr_addr_i,
  input  logic                     clr_all_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_c_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Reservation beats a same-cycle write clear; clear-all beats both. Entry 0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i)  busy_d[clr_addr_i] = 1'b0;
    if (set_en_i)  busy_d[set_addr_i] = 1'b1;
    if (clr_all_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    rd_busy_c_o = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      rd_busy_c_o[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard and sequenced clear sweep.
// Optional same-cycle write forwarding to read ports: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  regfile_mp_if.slave  bus
);

  localparam int unsigned       DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q;
  logic              sweep_we;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NUM_RD-1:0] sb_busy;
  logic [ADDR_W-1:0] rd_a;

  logic idle, wr_acc, rsv_acc, clr_start;

  assign idle      = (state_q == ST_IDLE);
  assign wr_acc    = bus.WrEn  && idle && (bus.WrAddr  != ZERO_A);
  assign rsv_acc   = bus.RsvEn && idle && (bus.RsvAddr != ZERO_A);
  assign clr_start = bus.ClrReq && idle;
  assign bus.Ready = ready_q;

  // Sweep walks ptr from 1 to DEPTH-1, zeroing one entry per cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ClrReq) begin
          state_d = ST_SWEEP;
          ptr_d   = ADDR_W'(1);
        end
      end
      ST_SWEEP: begin
        sweep_we = 1'b1;
        ptr_d    = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_A) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (sweep_we) mem_q[ptr_q]      <= '0;
      if (wr_acc)   mem_q[bus.WrAddr] <= bus.WrData;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .set_en_i    (rsv_acc),
    .set_addr_i  (bus.RsvAddr),
    .clr_en_i    (wr_acc),
    .clr_addr_i  (bus.WrAddr),
    .clr_all_i   (clr_start),
    .rd_addr_i   (bus.RdAddr),
    .rd_busy_c_o (sb_busy)
  );

  // Read mux; address 0 always reads as zero and not busy.
  always_comb begin
    bus.RdData = '0;
    bus.RdBusy = '0;
    rd_a       = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      rd_a = bus.RdAddr[k*ADDR_W +: ADDR_W];
      if (rd_a != ZERO_A) begin
        bus.RdData[k*DATA_W +: DATA_W] = mem_q[rd_a];
        bus.RdBusy[k]                  = sb_busy[k];
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && (bus.WrAddr == rd_a)) begin
          bus.RdData[k*DATA_W +: DATA_W] = bus.WrData;
          if (!(rsv_acc && (bus.RsvAddr == rd_a))) bus.RdBusy[k] = 1'b0;
        end
`else
        if (rsv_acc && (bus.RsvAddr == rd_a)) bus.RdBusy[k] = sb_busy[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, clear-sweep/reset sequences, random vs. model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: array contents, pending bits, remaining sweep cycles.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  int            sweep_left = 0;

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          re;
    logic [4:0]  ra;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          b0;
    bit          b1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdata(input int k);
    return bus.RdData[k*DW +: DW];
  endfunction

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.RdAddr = {a1, a0};
  endtask

  task automatic quiet();
    bus.WrEn   = 1'b0;
    bus.WrAddr = '0;
    bus.WrData = '0;
    bus.RsvEn  = 1'b0;
    bus.RsvAddr = '0;
    bus.ClrReq = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      sweep_left = 0;
    end else if (sweep_left > 0) begin
      m_mem[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (bus.WrEn && bus.WrAddr != 0) begin
        m_mem[bus.WrAddr]  = bus.WrData;
        m_busy[bus.WrAddr] = 1'b0;
      end
      if (bus.RsvEn && bus.RsvAddr != 0) m_busy[bus.RsvAddr] = 1'b1;
      if (bus.ClrReq) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        sweep_left = DEPTH - 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [4:0]    a;
    logic [DW-1:0] ed;
    bit            eb;
    chk($sformatf("%s_ready", tag), 64'(bus.Ready), 64'(sweep_left == 0));
    for (int k = 0; k < NR; k++) begin
      a  = bus.RdAddr[k*AW +: AW];
      ed = (a == 0) ? '0 : m_mem[a];
      eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (sweep_left == 0 && bus.WrEn && a != 0 && bus.WrAddr == a) begin
        ed = bus.WrData;
        if (!(bus.RsvEn && bus.RsvAddr == a)) eb = 1'b0;
      end
`endif
      chk($sformatf("%s_data%0d", tag, k), 64'(rdata(k)), 64'(ed));
      chk($sformatf("%s_busy%0d", tag, k), 64'(bus.RdBusy[k]), 64'(eb));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(5'(a), 5'(DEPTH - 1 - a));
      #1;
      chk($sformatf("%s_d0_a%0d", tag, a), 64'(rdata(0)), 64'h0);
      chk($sformatf("%s_d1_a%0d", tag, a), 64'(rdata(1)), 64'h0);
      chk($sformatf("%s_b_a%0d", tag, a), 64'(bus.RdBusy), 64'h0);
    end
  endtask

  task automatic fill_all();
    for (int a = 1; a < DEPTH; a++) begin
      bus.WrEn   = 1'b1;
      bus.WrAddr = 5'(a);
      bus.WrData = $urandom | 32'h1;
      tick();
    end
    bus.WrEn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;

    tbl[0] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd0, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[4] = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       1'b0, 1'b0};
    tbl[5] = '{1'b1, 5'd9, 32'hCAFE,     1'b1, 5'd9, 5'd9, 5'd5, 32'hCAFE,     32'hDEADBEEF, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'hCAFE,     1'b0, 1'b1};
    tbl[7] = '{1'b1, 5'd9, 32'h1111,     1'b0, 5'd0, 5'd9, 5'd7, 32'h1111,     32'h55,       1'b0, 1'b0};

    rst = 1'b1;
    quiet();
    set_rd(5'd0, 5'd0);
    tick();
    rst = 1'b0;

    // Reset state across every address.
    chk("reset_ready", 64'(bus.Ready), 64'h1);
    check_all_zero("reset");

    // Directed table: drive one cycle, then read back with strobes idle.
    for (int i = 0; i < 8; i++) begin
      bus.WrEn    = tbl[i].we;
      bus.WrAddr  = tbl[i].wa;
      bus.WrData  = tbl[i].wd;
      bus.RsvEn   = tbl[i].re;
      bus.RsvAddr = tbl[i].ra;
      tick();
      quiet();
      set_rd(tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(bus.Ready), 64'h1);
      chk($sformatf("tbl%0d_d0", i), 64'(rdata(0)), 64'(tbl[i].d0));
      chk($sformatf("tbl%0d_d1", i), 64'(rdata(1)), 64'(tbl[i].d1));
      chk($sformatf("tbl%0d_b0", i), 64'(bus.RdBusy[0]), 64'(tbl[i].b0));
      chk($sformatf("tbl%0d_b1", i), 64'(bus.RdBusy[1]), 64'(tbl[i].b1));
    end

    // Same-cycle view of a write to r4: forwarded only with bypass enabled.
    bus.WrEn   = 1'b1;
    bus.WrAddr = 5'd4;
    bus.WrData = 32'hA5A5;
    set_rd(5'd4, 5'd4);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_d0", 64'(rdata(0)), 64'hA5A5);
    chk("bypass_b0", 64'(bus.RdBusy[0]), 64'h0);
`else
    chk("no_bypass_d0", 64'(rdata(0)), 64'h0);
`endif
    tick();
    quiet();
    #1;
    chk("r4_after_write", 64'(rdata(1)), 64'hA5A5);

    // Full sweep with a pending reservation and writes attempted during it.
    fill_all();
    bus.RsvEn   = 1'b1;
    bus.RsvAddr = 5'd3;
    tick();
    quiet();
    set_rd(5'd3, 5'd0);
    #1;
    chk("pre_sweep_busy3", 64'(bus.RdBusy[0]), 64'h1);
    bus.ClrReq = 1'b1;
    tick();
    bus.ClrReq = 1'b0;
    chk("sweep_ready_low", 64'(bus.Ready), 64'h0);
    bus.WrEn   = 1'b1;
    bus.WrAddr = 5'd2;
    bus.WrData = 32'hFFFF;
    bus.RsvEn  = 1'b1;
    bus.RsvAddr = 5'd6;
    n = 0;
    while (bus.Ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    quiet();
    chk("sweep_len", 64'(n), 64'd31);
    check_all_zero("post_sweep");

    // Reset at sweep cycle 10 aborts the sweep and clears everything.
    fill_all();
    bus.ClrReq = 1'b1;
    tick();
    bus.ClrReq = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_sweep_ready", 64'(bus.Ready), 64'h0);
    rst = 1'b1;
    bus.WrEn   = 1'b1;
    bus.WrAddr = 5'd20;
    bus.WrData = 32'h77;
    tick();
    rst = 1'b0;
    quiet();
    chk("reset_abort_ready", 64'(bus.Ready), 64'h1);
    check_all_zero("reset_abort");

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 3000; i++) begin
      bus.WrEn    = 1'($urandom_range(0, 1));
      bus.WrAddr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      bus.WrData  = $urandom;
      bus.RsvEn   = ($urandom_range(0, 2) == 0);
      bus.RsvAddr = 5'($urandom_range(0, 7));
      bus.ClrReq  = ($urandom_range(0, 199) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      set_rd(5'($urandom_range(0, 7)), 5'($urandom));
      #1;
      check_model($sformatf("rnd%0d", i));
      tick();
    end
    rst = 1'b0;
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
